// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared definitions for the pipeline stall/flush controller.
// Holds the controller state encoding, the default multiply/divide freeze
// length and memory watchdog limit, and a small saturating-increment helper.
package pipe_ctrl_pkg;

  // Controller states; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_MD_BUSY  = 2'b10
  } state_e;

  // Frozen cycles per multiply/divide issue (legal 2..15).
  localparam int MD_CYCLES_DEF = 5;
  // MEM_WAIT cycles tolerated before the watchdog flag sets (legal 1..255).
  localparam int WDOG_DEF      = 255;

  // 8-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    logic [7:0] res;
    if (val == 8'hFF) begin
      res = val;
    end else begin
      res = val + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- bundle of hazard inputs and pipeline control outputs.
//   Hazard side : hdu_stall, br_taken_d, md_start_e, dm_req_m, dm_ack
//   Control side: pc_en, fd_en, de_en, em_en, mw_en, fd_clr, de_clr, em_clr
//   Status      : state, stall_cnt, flush_cnt, wdog_err
// master = pipeline/environment side, slave = pipe_ctrl.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic        hdu_stall;
  logic        br_taken_d;
  logic        md_start_e;
  logic        dm_req_m;
  logic        dm_ack;

  logic        pc_en;
  logic        fd_en;
  logic        de_en;
  logic        em_en;
  logic        mw_en;
  logic        fd_clr;
  logic        de_clr;
  logic        em_clr;

  state_e      state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        wdog_err;

  modport master (
    output hdu_stall, br_taken_d, md_start_e, dm_req_m, dm_ack,
    input  pc_en, fd_en, de_en, em_en, mw_en, fd_clr, de_clr, em_clr,
    input  state, stall_cnt, flush_cnt, wdog_err
  );

  modport slave (
    input  hdu_stall, br_taken_d, md_start_e, dm_req_m, dm_ack,
    output pc_en, fd_en, de_en, em_en, mw_en, fd_clr, de_clr, em_clr,
    output state, stall_cnt, flush_cnt, wdog_err
  );

endinterface

// File: rtl/pipe_ctrl_sat_cnt16.sv
// sat_cnt16 -- 16-bit event counter that stops at 16'hFFFF.
//   clk   : clock
//   rst_n : asynchronous active-low clear
//   inc   : count this cycle
//   cnt   : registered count
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] cnt_r;

  // Count register: increments on inc, holds once saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'h0000;
    end else if (inc && (cnt_r != 16'hFFFF)) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- 5-stage pipeline stall/flush controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipe_ctrl_if.slave (hazard inputs, register enables/clears,
//                state, stall/flush statistics, memory watchdog flag)
// Enables and clears are combinational from state, the MD counter and the
// current inputs; state, counters and the watchdog flag are registered.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF,
  parameter int WDOG      = WDOG_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);

  // The issue cycle is the first frozen cycle, so the counter covers the rest.
  localparam logic [3:0] MD_LOAD   = 4'(MD_CYCLES - 1);
  // Wait count value at the start of the WDOG-th MEM_WAIT cycle.
  localparam logic [7:0] WDOG_LAST = 8'(WDOG - 1);

  state_e      state_r;
  state_e      state_nxt_s;
  logic [3:0]  md_cnt_r;
  logic [3:0]  md_cnt_nxt_s;
  logic [7:0]  wait_cnt_r;
  logic [7:0]  wait_cnt_nxt_s;
  logic        wdog_err_r;
  logic        wdog_set_s;

  logic        pc_en_s;
  logic        fd_en_s;
  logic        de_en_s;
  logic        em_en_s;
  logic        mw_en_s;
  logic        fd_clr_s;
  logic        de_clr_s;
  logic        em_clr_s;

  // Control decode and next state; priority memory wait > MD > stall > branch.
  always_comb begin
    pc_en_s      = 1'b1;
    fd_en_s      = 1'b1;
    de_en_s      = 1'b1;
    em_en_s      = 1'b1;
    mw_en_s      = 1'b1;
    fd_clr_s     = 1'b0;
    de_clr_s     = 1'b0;
    em_clr_s     = 1'b0;
    state_nxt_s  = state_r;
    md_cnt_nxt_s = md_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (bus.dm_req_m && !bus.dm_ack) begin
          pc_en_s     = 1'b0;
          fd_en_s     = 1'b0;
          de_en_s     = 1'b0;
          em_en_s     = 1'b0;
          mw_en_s     = 1'b0;
          state_nxt_s = ST_MEM_WAIT;
        end else if (bus.md_start_e) begin
          // Hold F/D/E, let older work drain through M/W behind a bubble.
          pc_en_s      = 1'b0;
          fd_en_s      = 1'b0;
          de_en_s      = 1'b0;
          em_clr_s     = 1'b1;
          md_cnt_nxt_s = MD_LOAD;
          state_nxt_s  = ST_MD_BUSY;
        end else if (bus.hdu_stall) begin
          // A stalled branch stays in D, so no flush this cycle.
          pc_en_s  = 1'b0;
          fd_en_s  = 1'b0;
          de_clr_s = 1'b1;
        end else if (bus.br_taken_d) begin
          fd_clr_s = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (!bus.dm_ack) begin
          pc_en_s = 1'b0;
          fd_en_s = 1'b0;
          de_en_s = 1'b0;
          em_en_s = 1'b0;
          mw_en_s = 1'b0;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_MD_BUSY: begin
        if (md_cnt_r != 4'd0) begin
          pc_en_s      = 1'b0;
          fd_en_s      = 1'b0;
          de_en_s      = 1'b0;
          em_clr_s     = 1'b1;
          md_cnt_nxt_s = md_cnt_r - 4'd1;
        end else begin
          // Release cycle: md_start_e here belongs to the instruction just finishing.
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s  = ST_RUN;
        md_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // Memory wait counter and watchdog trip detection.
  always_comb begin
    wait_cnt_nxt_s = wait_cnt_r;
    wdog_set_s     = 1'b0;
    if ((state_r == ST_RUN) && (state_nxt_s == ST_MEM_WAIT)) begin
      wait_cnt_nxt_s = 8'h00;
    end else if (state_r == ST_MEM_WAIT) begin
      wait_cnt_nxt_s = sat_inc8(wait_cnt_r);
    end else begin
      wait_cnt_nxt_s = wait_cnt_r;
    end
    // Trips as the count reaches WDOG with the access still outstanding.
    if ((state_r == ST_MEM_WAIT) && !bus.dm_ack && (wait_cnt_r == WDOG_LAST)) begin
      wdog_set_s = 1'b1;
    end else begin
      wdog_set_s = 1'b0;
    end
  end

  // State, MD counter, wait counter and sticky watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      md_cnt_r   <= 4'd0;
      wait_cnt_r <= 8'h00;
      wdog_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      md_cnt_r   <= md_cnt_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      wdog_err_r <= wdog_err_r | wdog_set_s;
    end
  end

  sat_cnt16 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_en_s),
    .cnt   (bus.stall_cnt)
  );

  sat_cnt16 u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fd_clr_s),
    .cnt   (bus.flush_cnt)
  );

  assign bus.pc_en    = pc_en_s;
  assign bus.fd_en    = fd_en_s;
  assign bus.de_en    = de_en_s;
  assign bus.em_en    = em_en_s;
  assign bus.mw_en    = mw_en_s;
  assign bus.fd_clr   = fd_clr_s;
  assign bus.de_clr   = de_clr_s;
  assign bus.em_clr   = em_clr_s;
  assign bus.state    = state_r;
  assign bus.wdog_err = wdog_err_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl (MD_CYCLES=5, WDOG=4).
// Directed table of vectors with hand-derived expectations, a reset-abort
// sequence, then random stimulus against a cycle-count reference model.
module tb_pipe_ctrl;

  localparam int MD_CYC = 5;
  localparam int WDOG_T = 4;

  // Control word: {pc_en, fd_en, de_en, em_en, mw_en, fd_clr, de_clr, em_clr}
  localparam logic [7:0] C_DEF  = 8'hF8;
  localparam logic [7:0] C_WAIT = 8'h00;
  localparam logic [7:0] C_MD   = 8'h19;
  localparam logic [7:0] C_HDU  = 8'h3A;
  localparam logic [7:0] C_BR   = 8'hFC;

  // Input word: {hdu_stall, br_taken_d, md_start_e, dm_req_m, dm_ack}
  typedef struct packed {
    logic [4:0]  in;
    logic [7:0]  ctrl;
    logic [1:0]  st;
    logic        wdog;
    logic [15:0] stall;
    logic [15:0] flush;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if bus_if ();

  pipe_ctrl #(.MD_CYCLES(MD_CYC), .WDOG(WDOG_T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_pass = 0;
  int n_total = 0;
  vec_t vq[$];

  logic [42:0] obs_s;
  assign obs_s = {bus_if.pc_en, bus_if.fd_en, bus_if.de_en, bus_if.em_en, bus_if.mw_en,
                  bus_if.fd_clr, bus_if.de_clr, bus_if.em_clr,
                  bus_if.state, bus_if.wdog_err, bus_if.stall_cnt, bus_if.flush_cnt};

  // Reference model: phase 0=running, 1=waiting on memory, 2=MD in progress.
  int m_phase, m_frozen, m_waits, m_stall, m_flush;
  bit m_wdog;

  task automatic check(input string name, input logic [42:0] exp);
    n_total++;
    if (obs_s === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got ctrl=%h st=%0d wdog=%0b stall=%0d flush=%0d, expected ctrl=%h st=%0d wdog=%0b stall=%0d flush=%0d",
               name, obs_s[42:35], obs_s[34:33], obs_s[32], obs_s[31:16], obs_s[15:0],
               exp[42:35], exp[34:33], exp[32], exp[31:16], exp[15:0]);
    end
  endtask

  task automatic drive(input logic [4:0] in);
    bus_if.hdu_stall  = in[4];
    bus_if.br_taken_d = in[3];
    bus_if.md_start_e = in[2];
    bus_if.dm_req_m   = in[1];
    bus_if.dm_ack     = in[0];
  endtask

  task automatic add(input logic [4:0] in, input logic [7:0] c, input logic [1:0] st,
                     input logic w, input int s, input int f);
    vec_t v;
    v.in = in; v.ctrl = c; v.st = st; v.wdog = w;
    v.stall = 16'(s); v.flush = 16'(f);
    vq.push_back(v);
  endtask

  task automatic model_reset();
    m_phase = 0; m_frozen = 0; m_waits = 0; m_stall = 0; m_flush = 0; m_wdog = 1'b0;
  endtask

  // Expected observation for this cycle, then advance the model one cycle.
  task automatic model_step(input logic [4:0] in, output logic [42:0] exp);
    logic hdu, br, md, req, ack;
    logic [7:0] c;
    int nphase;
    {hdu, br, md, req, ack} = in;
    c = C_DEF;
    nphase = m_phase;
    if (m_phase == 1) begin
      if (!ack) c = C_WAIT; else nphase = 0;
    end else if (m_phase == 2) begin
      if (m_frozen < MD_CYC) c = C_MD; else nphase = 0;
    end else begin
      if (req && !ack) begin c = C_WAIT; nphase = 1; end
      else if (md) begin c = C_MD; nphase = 2; end
      else if (hdu) c = C_HDU;
      else if (br) c = C_BR;
    end
    exp = {c, 2'(m_phase), m_wdog, 16'(m_stall), 16'(m_flush)};
    if (m_phase == 0 && nphase == 1) m_waits = 0;
    if (m_phase == 1 && !ack) begin
      m_waits++;
      if (m_waits >= WDOG_T) m_wdog = 1'b1;
    end
    if (c == C_MD) m_frozen = (m_phase == 0) ? 1 : m_frozen + 1;
    if (!c[7] && m_stall < 65535) m_stall++;
    if (c[2] && m_flush < 65535) m_flush++;
    m_phase = nphase;
  endtask

  initial begin
    logic [42:0] exp;
    logic [4:0] r;

    drive(5'b00000);
    @(negedge clk);
    check("reset_state", {C_DEF, 2'd0, 1'b0, 16'd0, 16'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;

    // MD freeze held request: 5 frozen cycles, release on the 6th.
    add(5'b00100, C_MD,   2'd0, 1'b0,  0, 0);
    add(5'b00100, C_MD,   2'd2, 1'b0,  1, 0);
    add(5'b00100, C_MD,   2'd2, 1'b0,  2, 0);
    add(5'b00100, C_MD,   2'd2, 1'b0,  3, 0);
    add(5'b00100, C_MD,   2'd2, 1'b0,  4, 0);
    add(5'b00100, C_DEF,  2'd2, 1'b0,  5, 0);
    add(5'b00000, C_DEF,  2'd0, 1'b0,  5, 0);
    // Stall beats branch, then branch alone flushes.
    add(5'b11000, C_HDU,  2'd0, 1'b0,  5, 0);
    add(5'b01000, C_BR,   2'd0, 1'b0,  6, 0);
    add(5'b00000, C_DEF,  2'd0, 1'b0,  6, 1);
    // Three cycles without ack, then ack.
    add(5'b00010, C_WAIT, 2'd0, 1'b0,  6, 1);
    add(5'b00010, C_WAIT, 2'd1, 1'b0,  7, 1);
    add(5'b00010, C_WAIT, 2'd1, 1'b0,  8, 1);
    add(5'b00011, C_DEF,  2'd1, 1'b0,  9, 1);
    add(5'b00000, C_DEF,  2'd0, 1'b0,  9, 1);
    // Memory wait takes precedence over a simultaneous MD issue.
    add(5'b00110, C_WAIT, 2'd0, 1'b0,  9, 1);
    add(5'b00111, C_DEF,  2'd1, 1'b0, 10, 1);
    add(5'b00100, C_MD,   2'd0, 1'b0, 10, 1);
    add(5'b00000, C_MD,   2'd2, 1'b0, 11, 1);
    add(5'b00000, C_MD,   2'd2, 1'b0, 12, 1);
    add(5'b00000, C_MD,   2'd2, 1'b0, 13, 1);
    add(5'b00000, C_MD,   2'd2, 1'b0, 14, 1);
    add(5'b00000, C_DEF,  2'd2, 1'b0, 15, 1);
    add(5'b00000, C_DEF,  2'd0, 1'b0, 15, 1);
    // Watchdog: trips after the 4th MEM_WAIT cycle, sticky after ack.
    add(5'b00010, C_WAIT, 2'd0, 1'b0, 15, 1);
    add(5'b00010, C_WAIT, 2'd1, 1'b0, 16, 1);
    add(5'b00010, C_WAIT, 2'd1, 1'b0, 17, 1);
    add(5'b00010, C_WAIT, 2'd1, 1'b0, 18, 1);
    add(5'b00010, C_WAIT, 2'd1, 1'b0, 19, 1);
    add(5'b00010, C_WAIT, 2'd1, 1'b1, 20, 1);
    add(5'b00011, C_DEF,  2'd1, 1'b1, 21, 1);
    add(5'b00000, C_DEF,  2'd0, 1'b1, 21, 1);
    // Request and ack in the same RUN cycle: no wait.
    add(5'b00011, C_DEF,  2'd0, 1'b1, 21, 1);
    add(5'b00000, C_DEF,  2'd0, 1'b1, 21, 1);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].in);
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {vq[i].ctrl, vq[i].st, vq[i].wdog, vq[i].stall, vq[i].flush});
      @(posedge clk); #1;
    end

    // Reset pulsed while MD_BUSY with counter=2.
    drive(5'b00100);
    @(negedge clk);
    check("md_abort_issue", {C_MD, 2'd0, 1'b1, 16'd21, 16'd1});
    @(posedge clk); #1;
    drive(5'b00000);
    @(negedge clk);
    check("md_abort_busy4", {C_MD, 2'd2, 1'b1, 16'd22, 16'd1});
    @(posedge clk); #1;
    @(negedge clk);
    check("md_abort_busy3", {C_MD, 2'd2, 1'b1, 16'd23, 16'd1});
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("md_abort_in_reset", {C_DEF, 2'd0, 1'b0, 16'd0, 16'd0});
    drive(5'b10000);
    @(negedge clk);
    check("reset_run_rules", {C_HDU, 2'd0, 1'b0, 16'd0, 16'd0});
    @(posedge clk); #1;
    drive(5'b00000);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("md_abort_after%0d", i), {C_DEF, 2'd0, 1'b0, 16'd0, 16'd0});
      @(posedge clk); #1;
    end

    // Random traffic against the reference model.
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      r[4] = ($urandom_range(0, 3) == 0);
      r[3] = ($urandom_range(0, 2) == 0);
      r[2] = ($urandom_range(0, 5) == 0);
      r[1] = ($urandom_range(0, 2) == 0);
      r[0] = ($urandom_range(0, 3) != 0);
      drive(r);
      @(negedge clk);
      model_step(r, exp);
      check($sformatf("rand%0d", i), exp);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MD_CYCLES, default 5: number of frozen cycles for a multiply/divide issue, legal range 2..15.
REQ-002 Parameter WDOG, default 255: maximum number of MEM_WAIT cycles before the error flag sets, legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 hdu_stall  in  1  load-use/branch-operand stall request from the hazard detection unit.
REQ-006 br_taken_d  in  1  branch/jump redirect resolved in D.
REQ-007 md_start_e  in  1  multiply/divide instruction is present in E.
REQ-008 dm_req_m  in  1  load/store is present in M.
REQ-009 dm_ack  in  1  data memory completes the M access this cycle.
REQ-010 pc_en, fd_en, de_en, em_en, mw_en  out  1 each  pipeline register load enables.
REQ-011 fd_clr, de_clr, em_clr  out  1 each  synchronous bubble insertion into F/D, D/E and E/M.
REQ-012 state  out  2  current FSM state; RUN=00, MEM_WAIT=01, MD_BUSY=10.
REQ-013 stall_cnt  out  16  count of cycles with pc_en=0, saturating.
REQ-014 flush_cnt  out  16  count of cycles with fd_clr=1, saturating.
REQ-015 wdog_err  out  1  sticky memory-timeout flag.

Function
REQ-016 The control outputs (enables and clears) SHALL be combinational from state, the MD counter and the current inputs; state, counters and wdog_err SHALL be registered.
REQ-017 Default (RUN, no event): all enables=1 and all clears=0.
REQ-018 Priority per cycle, highest first: memory wait > MD freeze > hdu_stall > br_taken_d.
REQ-019 Memory wait (RUN with dm_req_m=1 and dm_ack=0, or MEM_WAIT with dm_ack=0): all five enables=0 and all clears=0; RUN moves to MEM_WAIT.
REQ-020 MEM_WAIT with dm_ack=1: outputs follow REQ-017; next state is RUN.
REQ-021 RUN with dm_req_m=1 and dm_ack=1 in the same cycle: no wait, and the state stays RUN.
REQ-022 MD issue (RUN, md_start_e=1, no memory wait): pc_en=fd_en=de_en=0, em_clr=1, em_en=1, mw_en=1; load the 4-bit MD counter with MD_CYCLES-1; next state is MD_BUSY.
REQ-023 In MD_BUSY with counter!=0, outputs are as in REQ-022 and the counter decrements by 1 per cycle.
REQ-024 In MD_BUSY with counter==0 (release cycle), outputs follow REQ-017, md_start_e is ignored, and the next state is RUN.
REQ-025 The total number of frozen cycles per MD instruction SHALL be exactly MD_CYCLES.
REQ-026 hdu_stall (RUN, no higher-priority event): pc_en=fd_en=0 and de_clr=1; the state is unchanged.
REQ-027 br_taken_d with no stall: fd_clr=1 with all enables=1.
REQ-028 br_taken_d together with any stall: fd_clr=0 and the stall wins; the branch stays in D and is re-evaluated in a later cycle.
REQ-029 stall_cnt SHALL increment on every cycle with pc_en=0 and hold at 16'hFFFF.
REQ-030 flush_cnt SHALL increment on every cycle with fd_clr=1 and hold at 16'hFFFF.
REQ-031 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle.
REQ-032 wdog_err SHALL set when the wait counter reaches WDOG while dm_ack=0, and SHALL stay set until reset.
REQ-033 Setting wdog_err SHALL NOT force a state change.

Reset
REQ-034 rst_n low SHALL immediately force state=RUN, MD counter=0, wait counter=0, stall_cnt=0, flush_cnt=0 and wdog_err=0.
REQ-035 During reset, the control outputs SHALL follow REQ-017 to REQ-028 for state RUN.
REQ-036 Reset asserted in MEM_WAIT or MD_BUSY SHALL abandon the operation with no residual freeze after release.

Structure
REQ-037 Package pipe_ctrl_pkg SHALL hold the state encodings and the MD_CYCLES and WDOG defaults.
REQ-038 One sub-module, sat_cnt16 (16-bit saturating counter with increment enable and async active-low clear), SHALL be instantiated twice.

Verification
REQ-039 md_start_e=1 held in RUN, MD_CYCLES=5 -> pc_en=0 for exactly 5 cycles, em_clr=1 on those 5 cycles, release on cycle 6, stall_cnt=5.
REQ-040 dm_req_m=1 with dm_ack low for 3 cycles then high -> all enables=0 for 3 cycles, state=01 during the wait, RUN after the ack cycle.
REQ-041 hdu_stall=1 and br_taken_d=1 in the same cycle -> pc_en=0, fd_en=0, de_clr=1, fd_clr=0; next cycle with br_taken_d only -> fd_clr=1, flush_cnt=1.
REQ-042 dm_req_m=1 and md_start_e=1 with dm_ack=0 -> state goes to MEM_WAIT first; MD freeze starts only after dm_ack=1.
REQ-043 dm_ack held 0 with WDOG=4 -> wdog_err=1 after the 4th MEM_WAIT cycle and remains 1 after the ack.
REQ-044 rst_n pulsed low mid-MD_BUSY (counter=2) -> state=00, all enables=1 with inputs low, both counters=0.
